// File: rtl/d_e_pipe_reg_pkg.sv
// d_e_pipe_reg_pkg: shared widths, reset/nop constants and the Tnew override helper for the D->E register
package d_e_pipe_reg_pkg;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TW = 2;
    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    function automatic logic [TW-1:0] tnew_eff(input logic [AW-1:0] a3, input logic [TW-1:0] tnew);
        return (a3 == '0) ? '0 : tnew;
    endfunction
endpackage

// File: rtl/d_e_pipe_reg_pipe_field.sv
// pipe_field: one pipeline-register field with async active-low reset value and a bubble value
module pipe_field #(
    parameter int W = 32,
    parameter logic [W-1:0] RV = '0,
    parameter logic [W-1:0] BV = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge reset)
        if (!reset) q <= RV;
        else q <= bubble ? BV : d;
endmodule

// File: rtl/d_e_pipe_reg.sv
// d_e_pipe_reg: D->E pipeline register with bubble injection and a saturating bubble counter
module d_e_pipe_reg
    import d_e_pipe_reg_pkg::*;
#(
    parameter int DW = d_e_pipe_reg_pkg::DW,
    parameter int AW = d_e_pipe_reg_pkg::AW,
    parameter int TW = d_e_pipe_reg_pkg::TW,
    parameter logic [DW-1:0] RESET_PC = d_e_pipe_reg_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic [DW-1:0] D_pc,
    input  logic [DW-1:0] D_instr,
    input  logic [DW-1:0] D_rs_data,
    input  logic [DW-1:0] D_rt_data,
    input  logic [DW-1:0] D_imm32,
    input  logic [AW-1:0] D_A3,
    input  logic [TW-1:0] D_Tnew,
    output logic [DW-1:0] E_pc,
    output logic [DW-1:0] E_instr,
    output logic [DW-1:0] E_rs_data,
    output logic [DW-1:0] E_rt_data,
    output logic [DW-1:0] E_imm32,
    output logic [AW-1:0] E_A3,
    output logic [TW-1:0] E_Tnew,
    output logic          E_valid,
    output logic [31:0]   bubble_cnt
);
    // pc keeps flowing through bubbles so a later EPC can still see it
    pipe_field #(.W(DW), .RV(RESET_PC)) u_pc (.clk, .reset, .bubble(1'b0), .d(D_pc), .q(E_pc));
    pipe_field #(.W(DW), .BV(DW'(NOP_INSTR))) u_instr (.clk, .reset, .bubble(stall), .d(D_instr), .q(E_instr));
    pipe_field #(.W(DW)) u_rs (.clk, .reset, .bubble(stall), .d(D_rs_data), .q(E_rs_data));
    pipe_field #(.W(DW)) u_rt (.clk, .reset, .bubble(stall), .d(D_rt_data), .q(E_rt_data));
    pipe_field #(.W(DW)) u_imm (.clk, .reset, .bubble(stall), .d(D_imm32), .q(E_imm32));
    pipe_field #(.W(AW)) u_a3 (.clk, .reset, .bubble(stall), .d(D_A3), .q(E_A3));
    pipe_field #(.W(TW)) u_tnew (.clk, .reset, .bubble(stall), .d(tnew_eff(D_A3, D_Tnew)), .q(E_Tnew));
    pipe_field #(.W(1)) u_valid (.clk, .reset, .bubble(stall), .d(1'b1), .q(E_valid));
    always_ff @(posedge clk or negedge reset)
        if (!reset) bubble_cnt <= '0;
        else if (stall && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
endmodule
